hilo_unit: RTL and testbench
============================

HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 The block SHALL have the port clk  input  1  rising-edge clock.
REQ-002 The block SHALL have the port rst  input  1  reset; synchronous, active-high.
REQ-003 The block SHALL have the port start  input  1  operation request, qualified by funct.
REQ-004 The block SHALL have the port funct  input  6  operation: 6'h19 MULTU, 6'h1B DIVU, 6'h10 MFHI, 6'h12 MFLO, 6'h11 MTHI, 6'h13 MTLO; any other value is a no-op.
REQ-005 The block SHALL have the port src_a  input  32  multiplicand / dividend / MTHI-MTLO data.
REQ-006 The block SHALL have the port src_b  input  32  multiplier / divisor.
REQ-007 The block SHALL have the port busy  output  1  high whenever state is not IDLE.
REQ-008 The block SHALL have the port done  output  1  one-cycle pulse when HI/LO hold a new result.
REQ-009 The block SHALL have the port stall  output  1  pipeline hold request.
REQ-010 The block SHALL have the port hilo_out  output  32  HI or LO value for the MEM/WB register.
REQ-011 The block SHALL have the port hi_sel  output  1  hilo_out carries HI (the MEM/WB Hi input).
REQ-012 The block SHALL have the port lo_sel  output  1  hilo_out carries LO (the MEM/WB Lo input).

Function
REQ-013 The block SHALL implement the states IDLE, MUL, DIV and DONE, with a 5-bit iteration counter cnt and internal 32-bit HI and LO registers.
REQ-014 IDLE SHALL transition to MUL with cnt=0 on a clock edge where start=1 and funct=MULTU, and SHALL latch src_a and src_b.
REQ-015 IDLE SHALL transition to DIV with cnt=0 on a clock edge where start=1, funct=DIVU and src_b!=0, and SHALL latch src_a and src_b.
REQ-016 MUL SHALL perform unsigned shift-add, one multiplier bit per cycle, producing a 64-bit product.
REQ-017 MUL SHALL write HI=product[63:32] and LO=product[31:0] on the edge of the iteration with cnt=31, and SHALL then go to DONE.
REQ-018 DIV SHALL perform restoring unsigned division, one quotient bit per cycle.
REQ-019 DIV SHALL write LO=quotient and HI=remainder on the edge of the iteration with cnt=31, and SHALL then go to DONE.
REQ-020 Latency SHALL be fixed: with start accepted at edge N, HI/LO are written at edge N+32, done=1 during cycle N+32, and the state returns to IDLE at edge N+33.
REQ-021 A DIVU with src_b=0 SHALL go from IDLE to DONE at edge N, writing HI=src_a and LO=32'hFFFFFFFF, so that done=1 during cycle N.
REQ-022 In IDLE, start=1 with funct=MTHI (MTLO) SHALL write src_a to HI (LO) at that edge, without asserting done or stall.
REQ-023 hilo_out SHALL be combinational: HI when funct=MFHI, otherwise LO.
REQ-024 hi_sel SHALL equal start & (funct==MFHI) & ~busy.
REQ-025 lo_sel SHALL equal start & (funct==MFLO) & ~busy.
REQ-026 stall SHALL equal start & busy & funct in {MULTU, DIVU, MFHI, MFLO, MTHI, MTLO}.
REQ-027 While busy, start SHALL be ignored: no state change, no HI/LO write, no latch of operands.
REQ-028 The DONE state SHALL count as busy, so an MFHI/MFLO issued in the DONE cycle stalls one cycle and then reads the new value.
REQ-029 Intermediate product and remainder values SHALL NOT be visible on hilo_out, because HI/LO change only at the final edge.
REQ-030 cnt SHALL NOT wrap past 31: the transition out of MUL/DIV is taken at cnt=31.

Reset
REQ-031 When rst=1 at a clock edge, the block SHALL set state=IDLE, cnt=0, HI=0 and LO=0, and SHALL clear the operand and product registers, so that busy=0 and done=0 in the next cycle.
REQ-032 rst SHALL take priority over all other inputs.
REQ-033 rst asserted mid-operation SHALL abort the operation with no HI/LO write.
REQ-034 stall, hi_sel and lo_sel SHALL be 0 while rst is held, because busy=0 and start is expected low.

Verification
REQ-035 Bench scenario: MULTU 7 x 6 at edge N -> busy=1 during cycles N+1 to N+32, done=1 only during cycle N+32, and after that edge HI=0 and LO=42.
REQ-036 Bench scenario: MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> HI=32'hFFFFFFFE and LO=32'h00000001 after 32 cycles.
REQ-037 Bench scenario: DIVU 100 / 7 -> LO=14 and HI=2 at edge N+32.
REQ-038 Bench scenario: DIVU 5 / 0 -> done=1 during cycle N, HI=5, LO=32'hFFFFFFFF, and busy=0 by cycle N+2.
REQ-039 Bench scenario: MFHI with start held during MULTU -> stall=1 and hi_sel=0 through the DONE cycle, then stall=0, hi_sel=1 and hilo_out equal to the new HI.
REQ-040 Bench scenario: rst at cycle 10 of a MULTU -> busy=0 the next cycle, HI=LO=0, and done never asserted.

Source files
------------

// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO register unit for a MIPS-style pipeline.
// Performs 32x32 unsigned multiply (MULTU) and unsigned divide (DIVU) as
// fixed-latency iterative operations, and services MFHI/MFLO/MTHI/MTLO.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     operation request, qualified by funct
//   funct     operation code (MULTU, DIVU, MFHI, MFLO, MTHI, MTLO)
//   src_a     multiplicand / dividend / MTHI-MTLO data
//   src_b     multiplier / divisor
//   busy      unit is not idle
//   done      one-cycle pulse when HI/LO hold a new result
//   stall     pipeline hold request
//   hilo_out  HI (for MFHI) or LO value toward MEM/WB
//   hi_sel    hilo_out carries HI into MEM/WB
//   lo_sel    hilo_out carries LO into MEM/WB
module hilo_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  funct,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        done,
    output logic        stall,
    output logic [31:0] hilo_out,
    output logic        hi_sel,
    output logic        lo_sel
);

    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state, state_next;
    logic [4:0]  cnt, cnt_next;
    logic [31:0] hi, hi_next;
    logic [31:0] lo, lo_next;
    // Multiplicand for MUL, divisor for DIV.
    logic [31:0] opnd, opnd_next;
    // MUL: {partial product high, remaining multiplier bits}.
    // DIV: {partial remainder, remaining dividend / growing quotient}.
    logic [63:0] acc, acc_next;

    logic [32:0] mul_sum;
    logic [63:0] mul_step;
    logic [32:0] div_diff;
    logic [63:0] div_step;
    logic        hilo_op;

    // One iteration of each algorithm. The multiply adds the multiplicand
    // into the upper half when the current multiplier LSB is set, then shifts
    // right. The divide shifts the remainder left by one dividend bit and
    // subtracts the divisor; bit 32 of the 33-bit difference is the borrow,
    // which decides whether the subtraction is kept (restoring division).
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        mul_step = {mul_sum, acc[31:1]};
        div_diff = acc[63:31] - {1'b0, opnd};
        div_step = div_diff[32] ? {acc[62:0], 1'b0}
                                : {div_diff[31:0], acc[30:0], 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 5'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            opnd  <= 32'd0;
            acc   <= 64'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            hi    <= hi_next;
            lo    <= lo_next;
            opnd  <= opnd_next;
            acc   <= acc_next;
        end
    end

    // Next-state logic. HI/LO only change on the final iteration edge, so
    // partial results never leak onto hilo_out. Requests arriving while
    // busy are ignored here; they are held off by stall instead.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        hi_next    = hi;
        lo_next    = lo;
        opnd_next  = opnd;
        acc_next   = acc;
        unique case (state)
            IDLE: begin
                if (start) begin
                    case (funct)
                        F_MULTU: begin
                            state_next = MUL;
                            cnt_next   = 5'd0;
                            opnd_next  = src_a;
                            acc_next   = {32'd0, src_b};
                        end
                        F_DIVU: begin
                            if (src_b == 32'd0) begin
                                state_next = DONE;
                                hi_next    = src_a;
                                lo_next    = 32'hFFFF_FFFF;
                            end else begin
                                state_next = DIV;
                                cnt_next   = 5'd0;
                                opnd_next  = src_b;
                                acc_next   = {32'd0, src_a};
                            end
                        end
                        F_MTHI:  hi_next = src_a;
                        F_MTLO:  lo_next = src_a;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                acc_next = mul_step;
                cnt_next = cnt + 5'd1;
                if (cnt == 5'd31) begin
                    state_next = DONE;
                    cnt_next   = 5'd0;
                    hi_next    = mul_step[63:32];
                    lo_next    = mul_step[31:0];
                end
            end
            DIV: begin
                acc_next = div_step;
                cnt_next = cnt + 5'd1;
                if (cnt == 5'd31) begin
                    state_next = DONE;
                    cnt_next   = 5'd0;
                    hi_next    = div_step[63:32];
                    lo_next    = div_step[31:0];
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Any HI/LO-related request while busy must hold the pipeline; DONE
    // counts as busy so a read issued then sees the freshly written value.
    always_comb begin
        hilo_op = (funct == F_MULTU) || (funct == F_DIVU) ||
                  (funct == F_MFHI)  || (funct == F_MFLO) ||
                  (funct == F_MTHI)  || (funct == F_MTLO);
        busy     = (state != IDLE);
        done     = (state == DONE);
        stall    = start & busy & hilo_op;
        hilo_out = (funct == F_MFHI) ? hi : lo;
        hi_sel   = start & (funct == F_MFHI) & ~busy;
        lo_sel   = start & (funct == F_MFLO) & ~busy;
    end

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed bench for hilo_unit. Reads of HI/LO (MFHI/MFLO)
// push their expected value into a scoreboard queue; a monitor pops and
// compares whenever the unit presents hi_sel or lo_sel. Timing of busy,
// done and stall is checked directly by the stimulus process.
module tb_hilo_unit;

    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] hilo_out;
    logic        hi_sel;
    logic        lo_sel;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        is_hi;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t expq[$];
    exp_t mon_item;

    hilo_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .funct    (funct),
        .src_a    (src_a),
        .src_b    (src_b),
        .busy     (busy),
        .done     (done),
        .stall    (stall),
        .hilo_out (hilo_out),
        .hi_sel   (hi_sel),
        .lo_sel   (lo_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [5:0] f,
                                 input logic [31:0] a, input logic [31:0] b);
        start = s;
        funct = f;
        src_a = a;
        src_b = b;
    endtask

    // Advance to just after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Issue an operation; returns in cycle N (just after accepting edge N).
    task automatic issueOp(input logic [5:0] f, input logic [31:0] a,
                           input logic [31:0] b);
        applyStimulus(1'b1, f, a, b);
        nextCycle();
        applyStimulus(1'b0, 6'h00, 32'd0, 32'd0);
    endtask

    // Request an MFHI/MFLO read in IDLE; the monitor does the comparison.
    task automatic readReg(input logic is_hi, input logic [31:0] exp_val,
                           input string name);
        exp_t item;
        item.is_hi = is_hi;
        item.val   = exp_val;
        item.name  = name;
        expq.push_back(item);
        applyStimulus(1'b1, is_hi ? F_MFHI : F_MFLO, 32'd0, 32'd0);
        @(negedge clk);
        nextCycle();
        applyStimulus(1'b0, 6'h00, 32'd0, 32'd0);
    endtask

    // Scoreboard monitor: every HI/LO read presented by the DUT is matched
    // against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (hi_sel === 1'b1 || lo_sel === 1'b1) begin
            if (expq.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_read: hi_sel=%b lo_sel=%b with no pending read",
                         hi_sel, lo_sel);
            end else begin
                mon_item = expq.pop_front();
                checkOutput({mon_item.name, "_hisel"}, {31'd0, hi_sel}, {31'd0, mon_item.is_hi});
                checkOutput(mon_item.name, hilo_out, mon_item.val);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic seen_done;

        rst = 1'b1;
        applyStimulus(1'b0, 6'h00, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_stall", {31'd0, stall}, 32'd0);
        nextCycle();
        readReg(1'b1, 32'd0, "reset_hi");
        readReg(1'b0, 32'd0, "reset_lo");

        // MULTU 7 x 6: busy through N+32, done only in N+32.
        issueOp(F_MULTU, 32'd7, 32'd6);
        for (int k = 1; k <= 33; k++) begin
            nextCycle();
            @(negedge clk);
            checkOutput($sformatf("mul7x6_busy_c%0d", k), {31'd0, busy}, {31'd0, (k <= 32)});
            checkOutput($sformatf("mul7x6_done_c%0d", k), {31'd0, done}, {31'd0, (k == 32)});
        end
        nextCycle();
        readReg(1'b0, 32'd42, "mul7x6_lo");
        readReg(1'b1, 32'd0, "mul7x6_hi");

        // MULTU max x max.
        issueOp(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (32) nextCycle();
        @(negedge clk);
        checkOutput("mulmax_done", {31'd0, done}, 32'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("mulmax_idle", {31'd0, busy}, 32'd0);
        nextCycle();
        readReg(1'b1, 32'hFFFF_FFFE, "mulmax_hi");
        readReg(1'b0, 32'h0000_0001, "mulmax_lo");

        // DIVU 100 / 7, with an MTLO attempted mid-operation (must be ignored).
        issueOp(F_DIVU, 32'd100, 32'd7);
        repeat (4) nextCycle();
        applyStimulus(1'b1, F_MTLO, 32'h0000_0055, 32'd0);
        @(negedge clk);
        checkOutput("div_mtlo_stall", {31'd0, stall}, 32'd1);
        nextCycle();
        applyStimulus(1'b0, 6'h00, 32'd0, 32'd0);
        repeat (27) nextCycle();
        @(negedge clk);
        checkOutput("div100_done", {31'd0, done}, 32'd1);
        nextCycle();
        nextCycle();
        readReg(1'b0, 32'd14, "div100_lo");
        readReg(1'b1, 32'd2, "div100_hi");

        // DIVU by zero finishes immediately.
        issueOp(F_DIVU, 32'd5, 32'd0);
        @(negedge clk);
        checkOutput("div0_done", {31'd0, done}, 32'd1);
        checkOutput("div0_busy", {31'd0, busy}, 32'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("div0_idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("div0_idle_done", {31'd0, done}, 32'd0);
        nextCycle();
        readReg(1'b1, 32'd5, "div0_hi");
        readReg(1'b0, 32'hFFFF_FFFF, "div0_lo");

        // MFHI held during a MULTU stalls until after DONE, then reads new HI.
        issueOp(F_MULTU, 32'h1234_5678, 32'h0000_0100);
        nextCycle();
        begin
            exp_t item;
            item.is_hi = 1'b1;
            item.val   = 32'h0000_0012;
            item.name  = "mfhi_after_mul";
            expq.push_back(item);
        end
        applyStimulus(1'b1, F_MFHI, 32'd0, 32'd0);
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            checkOutput($sformatf("mfhi_stall_c%0d", k), {31'd0, stall}, 32'd1);
            checkOutput($sformatf("mfhi_hisel_c%0d", k), {31'd0, hi_sel}, 32'd0);
            if (k == 16)
                checkOutput("mfhi_old_hi_visible", hilo_out, 32'd5);
            if (k == 32)
                checkOutput("mfhi_done", {31'd0, done}, 32'd1);
            nextCycle();
        end
        @(negedge clk);
        checkOutput("mfhi_stall_released", {31'd0, stall}, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 6'h00, 32'd0, 32'd0);
        readReg(1'b0, 32'h3456_7800, "mul_shift_lo");

        // MTHI / MTLO write without done or stall.
        applyStimulus(1'b1, F_MTHI, 32'hDEAD_BEEF, 32'd0);
        @(negedge clk);
        checkOutput("mthi_done", {31'd0, done}, 32'd0);
        checkOutput("mthi_stall", {31'd0, stall}, 32'd0);
        nextCycle();
        applyStimulus(1'b1, F_MTLO, 32'hCAFE_F00D, 32'd0);
        @(negedge clk);
        checkOutput("mtlo_done", {31'd0, done}, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 6'h00, 32'd0, 32'd0);
        @(negedge clk);
        checkOutput("mtlo_busy", {31'd0, busy}, 32'd0);
        nextCycle();
        readReg(1'b1, 32'hDEAD_BEEF, "mthi_hi");
        readReg(1'b0, 32'hCAFE_F00D, "mtlo_lo");

        // Unrecognised funct is a no-op.
        applyStimulus(1'b1, 6'h20, 32'd1, 32'd2);
        nextCycle();
        applyStimulus(1'b0, 6'h00, 32'd0, 32'd0);
        @(negedge clk);
        checkOutput("noop_busy", {31'd0, busy}, 32'd0);
        nextCycle();

        // Reset in the middle of a MULTU aborts it and clears HI/LO.
        issueOp(F_MULTU, 32'd3, 32'd5);
        repeat (9) nextCycle();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_hold_stall", {31'd0, stall}, 32'd0);
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        seen_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            nextCycle();
            @(negedge clk);
            if (done === 1'b1)
                seen_done = 1'b1;
        end
        checkOutput("abort_no_done", {31'd0, seen_done}, 32'd0);
        nextCycle();
        readReg(1'b1, 32'd0, "abort_hi");
        readReg(1'b0, 32'd0, "abort_lo");

        nextCycle();
        checkOutput("pending_reads", expq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
